// File: rtl/reg_sel_decoder_pkg.sv
// reg_sel_pkg: shared sizing and FSM state type for the register-select
// burst decoder.
//   NREGS  number of selectable registers (width of the one-hot select)
//   IDX_W  width of a register index
//   CNT_W  width of a burst count (1..32, 0 treated as 1)
package reg_sel_pkg;
  localparam int NREGS = 32;
  localparam int IDX_W = 5;
  localparam int CNT_W = 6;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;
endpackage

// File: rtl/reg_sel_decoder_dec5to32.sv
// dec5to32: combinational 5-to-32 one-hot decoder.
//   idx    in   binary register index
//   onehot out  bit idx set, all others clear
module dec5to32
  import reg_sel_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  output logic [NREGS-1:0] onehot
);
  always_comb begin
    onehot = '0;
    onehot[idx] = 1'b1;
  end
endmodule

// File: rtl/reg_sel_decoder.sv
// reg_sel_decoder: turns a (start_idx, count) request into a burst of
// one-hot register selects, one beat per consumer handshake.
//   clock, clear_n        clock, async active-low reset
//   in_valid/in_ready     request handshake (ready only in IDLE)
//   start_idx, count      first index and beat count (0 treated as 1)
//   out_valid/out_ready   beat handshake
//   out_onehot, out_idx   current select, one-hot and binary
//   out_last, out_trunc   final beat / burst cut short at index 31
// Parameter DRIVE_ZERO: 1 = out_onehot is zero while out_valid=0,
//                       0 = out_onehot holds the last beat's value.
// Macro REG_SEL_DECODER_WRAP_EN: when defined, idx wraps 31->0 and every
// requested beat is delivered; otherwise a burst stops at index 31.
module reg_sel_decoder
  import reg_sel_pkg::*;
#(
  parameter bit DRIVE_ZERO = 1'b1
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] start_idx,
  input  logic [CNT_W-1:0] count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NREGS-1:0] out_onehot,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_trunc
);
  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic [CNT_W-1:0] rem_q;
  logic [NREGS-1:0] dec_w;
  logic             accept, beat_done, at_top, last_w;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == BURST);
  assign accept    = in_valid && in_ready;
  assign beat_done = out_valid && out_ready;

`ifdef REG_SEL_DECODER_WRAP_EN
  assign at_top = 1'b0;
`else
  // Without wrap, index 31 always ends the burst.
  assign at_top = (idx_q == IDX_W'(NREGS - 1));
`endif

  assign last_w    = (rem_q == CNT_W'(1)) || at_top;
  assign out_last  = out_valid && last_w;
  // Truncated only when beats were still owed past index 31.
  assign out_trunc = out_valid && at_top && (rem_q != CNT_W'(1));
  assign out_idx   = idx_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)           state_d = BURST;
      BURST:   if (out_ready && last_w) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        idx_q <= start_idx;
        rem_q <= (count == '0) ? CNT_W'(1) : count;
      end else if (beat_done) begin
        idx_q <= idx_q + IDX_W'(1);
        rem_q <= rem_q - CNT_W'(1);
      end
    end
  end

  dec5to32 u_dec (
    .idx    (idx_q),
    .onehot (dec_w)
  );

  generate
    if (DRIVE_ZERO) begin : g_zero
      assign out_onehot = out_valid ? dec_w : '0;
    end else begin : g_hold
      logic [NREGS-1:0] hold_q;
      always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n)       hold_q <= '0;
        else if (out_valid) hold_q <= dec_w;
      end
      assign out_onehot = out_valid ? dec_w : hold_q;
    end
  endgenerate
endmodule

// File: tb/tb_reg_sel_decoder.sv
// Randomized self-checking bench for reg_sel_decoder (DRIVE_ZERO=1).
// The reference expands each request into its list of expected beats.
module tb_reg_sel_decoder;
  logic        clock = 1'b0;
  logic        clear_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  start_idx = '0;
  logic [5:0]  count = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_onehot;
  logic [4:0]  out_idx;
  logic        out_last;
  logic        out_trunc;

  int errs = 0;
  int checks = 0;

  reg_sel_decoder #(.DRIVE_ZERO(1'b1)) dut (
    .clock(clock), .clear_n(clear_n), .in_valid(in_valid), .in_ready(in_ready),
    .start_idx(start_idx), .count(count), .out_valid(out_valid),
    .out_ready(out_ready), .out_onehot(out_onehot), .out_idx(out_idx),
    .out_last(out_last), .out_trunc(out_trunc)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: list of beat indices plus flags on the final one.
  int  e_idx[$];
  bit  e_trunc;

  task automatic model(input int s, input int c);
    int n, avail;
    e_idx.delete();
    n = (c == 0) ? 1 : c;
    e_trunc = 0;
`ifndef REG_SEL_DECODER_WRAP_EN
    avail = 32 - s;
    if (n > avail) begin
      n = avail;
      e_trunc = 1;
    end
`endif
    for (int k = 0; k < n; k++) e_idx.push_back((s + k) % 32);
  endtask

  // Issue a request and walk its beats. pat_en selects a fixed out_ready
  // pattern (bit per cycle) instead of random backpressure.
  task automatic run_burst(input int s, input int c, input bit pat_en, input logic [31:0] pat);
    int k, cyc, n;
    bit rdy, lst;
    model(s, c);
    n = e_idx.size();
    @(negedge clock);
    chk("idle_ready", {31'b0, in_ready}, 32'd1);
    chk("idle_valid", {31'b0, out_valid}, 32'd0);
    in_valid  = 1'b1;
    start_idx = 5'(s);
    count     = 6'(c);
    out_ready = 1'($urandom);  // irrelevant in IDLE
    @(negedge clock);
    in_valid = 1'b0;
    k = 0;
    cyc = 0;
    while (k < n) begin
      if (cyc > 0) @(negedge clock);
      lst = (k == n - 1);
      chk("beat_valid", {31'b0, out_valid}, 32'd1);
      chk("beat_idx", {27'b0, out_idx}, 32'(e_idx[k]));
      chk("beat_onehot", out_onehot, 32'd1 << e_idx[k]);
      chk("beat_last", {31'b0, out_last}, {31'b0, lst});
      chk("beat_trunc", {31'b0, out_trunc}, {31'b0, lst && e_trunc});
      if (pat_en)         rdy = pat[cyc % 32];
      else if (cyc > 200) rdy = 1'b1;
      else                rdy = 1'($urandom);
      out_ready = rdy;
      if (rdy) k++;
      cyc++;
      if (cyc > 400) begin
        chk("burst_timeout", 32'(cyc), 32'(0));
        break;
      end
    end
    @(negedge clock);
    out_ready = 1'b0;
    chk("end_valid", {31'b0, out_valid}, 32'd0);
    chk("end_onehot", out_onehot, 32'd0);
    chk("end_ready", {31'b0, in_ready}, 32'd1);
    chk("end_last", {31'b0, out_last}, 32'd0);
  endtask

  initial begin
    #12;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_onehot", out_onehot, 32'd0);
    chk("rst_idx", {27'b0, out_idx}, 32'd0);
    chk("rst_last", {31'b0, out_last}, 32'd0);
    chk("rst_trunc", {31'b0, out_trunc}, 32'd0);
    chk("rst_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clock);
    clear_n = 1'b1;

    // Directed cases
    run_burst(5, 1, 1'b1, 32'hFFFF_FFFF);
    run_burst(2, 3, 1'b1, 32'hFFFF_FFFD);   // ready 1,0,1,1
    run_burst(31, 0, 1'b1, 32'hFFFF_FFFF);
    run_burst(30, 4, 1'b1, 32'hFFFF_FFFF);
    run_burst(0, 32, 1'b1, 32'hFFFF_FFFF);
    run_burst(31, 32, 1'b0, 32'h0);

    // Reset mid-burst: start 4, count 8, pull clear_n after 3 beats
    @(negedge clock);
    in_valid = 1'b1; start_idx = 5'd4; count = 6'd8; out_ready = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    repeat (3) @(negedge clock);
    chk("mid_idx", {27'b0, out_idx}, 32'd7);
    #2 clear_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_onehot", out_onehot, 32'd0);
    chk("mid_rst_idx", {27'b0, out_idx}, 32'd0);
    chk("mid_rst_last", {31'b0, out_last}, 32'd0);
    @(negedge clock);
    clear_n = 1'b1;
    repeat (2) @(negedge clock);
    chk("post_rst_ready", {31'b0, in_ready}, 32'd1);
    chk("post_rst_valid", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b0;

    // Random requests
    for (int i = 0; i < 40; i++)
      run_burst(int'($urandom_range(0, 31)), int'($urandom_range(0, 32)), 1'b0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/reg_sel_decoder.md
REG_SEL_DECODER -- requirements
Module: reg_sel_decoder

Interface
REQ-001 Parameter DRIVE_ZERO, default 1; when 1, out_onehot is 32'h0 whenever out_valid=0; when 0, out_onehot holds its last value.
REQ-002 clock  input  1  single clock; all state updates on the rising edge.
REQ-003 clear_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  request present.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 start_idx  input  5  first register index of the burst.
REQ-007 count  input  6  number of registers to select; 1..32, with 0 treated as 1.
REQ-008 out_valid  output  1  out_onehot/out_idx are valid this cycle.
REQ-009 out_ready  input  1  consumer accepts the current beat.
REQ-010 out_onehot  output  32  one-hot register select, bit out_idx set.
REQ-011 out_idx  output  5  binary index of the current beat.
REQ-012 out_last  output  1  current beat is the final beat of the burst.
REQ-013 out_trunc  output  1  burst was cut short at index 31; meaningful only with out_last.

Function
REQ-014 The FSM SHALL have two states: IDLE and BURST.
REQ-015 in_ready SHALL be 1 in IDLE and 0 in BURST.
REQ-016 A request is accepted on a rising edge where in_valid=1 and in_ready=1: latch start_idx into idx, latch count into remaining (0 becomes 1), go to BURST.
REQ-017 out_valid SHALL rise on the clock edge that accepts a request, giving 1-cycle latency from the accept cycle to the first beat; out_valid SHALL be 1 throughout BURST.
REQ-018 out_onehot SHALL equal 1<<idx while out_valid=1; exactly one bit is set.
REQ-019 A beat completes on a rising edge where out_valid=1 and out_ready=1; on completion idx increments and remaining decrements.
REQ-020 While out_ready=0, all outputs SHALL hold stable.
REQ-021 out_last SHALL be 1 when remaining=1, or when idx=31 in non-wrap mode (see Configuration).
REQ-022 Completion of a beat with out_last=1 SHALL return the FSM to IDLE and drop out_valid on that edge.
REQ-023 After the last beat completes there is one IDLE cycle before the next accept; back-to-back bursts are not overlapped.
REQ-024 In IDLE, in_valid=1 together with out_ready SHALL have no effect on outputs other than the accept.
REQ-025 count=32 with start_idx=0 SHALL produce 32 beats, idx 0..31, with out_last on idx 31 and out_trunc=0.

Reset
REQ-026 clear_n=0 SHALL immediately and asynchronously force IDLE, out_valid=0, out_onehot=0, out_idx=0, out_last=0, out_trunc=0, in_ready=1 after reset, and clear internal idx/remaining to 0.
REQ-027 Reset asserted mid-burst SHALL abandon the burst; no beat resumes after release.

Configuration
REQ-028 Macro REG_SEL_DECODER_WRAP_EN defined: idx SHALL wrap from 31 to 0, all count beats are delivered, and out_trunc SHALL be held 0.
REQ-029 Macro REG_SEL_DECODER_WRAP_EN undefined: if start_idx+count>32, the beat at idx 31 SHALL carry out_last=1 and out_trunc=1, and the burst ends there.

Structure
REQ-030 Shared package reg_sel_pkg SHALL hold: NREGS=32, IDX_W=5, CNT_W=6, and the state typedef {IDLE, BURST}.
REQ-031 The combinational 5-to-32 one-hot decode SHALL be a sub-module named dec5to32, instantiated once; all sequencing stays in reg_sel_decoder.

Verification
REQ-032 Reset mid-burst: start 4, count 8, clear_n pulse after 3 beats -> out_valid=0 and out_onehot=0 immediately; in_ready=1 after release.
REQ-033 Single request: start 5, count 1, out_ready=1 -> the next cycle shows out_onehot=32'h20, out_idx=5, out_last=1; then IDLE.
REQ-034 Burst with backpressure: start 2, count 3, out_ready toggled 1,0,1,1 -> beats 0x4, 0x8, 0x10 in order, each held while stalled; out_last on 0x10.
REQ-035 Count zero: start 31, count 0 -> exactly one beat, 32'h80000000 with out_last=1.
REQ-036 Overflow: start 30, count 4 -> without the macro, beats 30 and 31 with out_trunc=1 on beat 31; with the macro, beats 30, 31, 0, 1 with out_trunc=0.
